// File: rtl/mult_inv_sched.sv
// rtl/mult_inv_sched.sv - round-robin scheduler sharing one MultInv core, with 2^-k correction
`ifndef PRIME
`define PRIME 23
`endif
`ifndef BW_GF
`define BW_GF 5
`endif

module mult_inv_sched #(
  parameter int NREQ      = 2,
  parameter int DRAIN_CYC = 600
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*`BW_GF-1:0]  req_a,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [2:0]              done_id,
  output logic [`BW_GF-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic                    mi_en,
  output logic [`BW_GF-1:0]       mi_a,
  input  logic [`BW_GF-1:0]       mi_value,
  input  logic [8:0]              mi_power,
  input  logic                    mi_valid
);
  localparam int BW = `BW_GF;
  localparam logic [BW:0] P = (BW+1)'(`PRIME);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_LAUNCH, S_WAIT, S_CORR, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [2:0]      rr_q, rr_d, idx_q, idx_d;
  logic [BW-1:0]   a_q, a_d;
  logic [BW:0]     t_q, t_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            done_q, done_d, busy_q, busy_d, en_q, en_d;
  logic            found;
  logic [2:0]      pick;
  logic [BW-1:0]   pick_a;
  logic [BW:0]     sum, val_ext;

  // Lowest-indexed request overall, overridden by the lowest at or above the rr pointer.
  always_comb begin
    found  = |req;
    pick   = '0;
    pick_a = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick   = 3'(i);
        pick_a = req_a[i*BW +: BW];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) >= rr_q)) begin
        pick   = 3'(i);
        pick_a = req_a[i*BW +: BW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum     = t_q + P;
    val_ext = {1'b0, mi_value};
    case (state_q)
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (mi_valid || (drain_q == DW'(DRAIN_CYC - 1))) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (found) begin
          idx_d   = pick;
          a_d     = pick_a;
          cnt_d   = '0;
          t_d     = '0;
          err_d   = (pick_a == '0) || ({1'b0, pick_a} >= P);
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = err_q ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (mi_valid) begin
          t_d     = (val_ext >= P) ? val_ext - P : val_ext;
          cnt_d   = mi_power;
          state_d = S_CORR;
        end
      end
      S_CORR: begin
        // t < p keeps t + p inside BW+1 bits.
        if (cnt_q != '0) begin
          t_d   = t_q[0] ? (sum >> 1) : (t_q >> 1);
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_d    = (idx_q == 3'(NREQ - 1)) ? 3'd0 : idx_q + 3'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_DRAIN;
    endcase

    gnt_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((3'(i) == idx_d) && (state_d inside {S_LAUNCH, S_WAIT, S_CORR, S_DONE})) gnt_d[i] = 1'b1;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    en_d   = (state_d == S_LAUNCH) && !err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DRAIN;
      drain_q <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = idx_q;
  assign result  = t_q[BW-1:0];
  assign err     = err_q && done_q;
  assign busy    = busy_q;
  assign mi_en   = en_q;
  assign mi_a    = a_q;
endmodule

// File: tb/tb_mult_inv_sched.sv
// tb/tb_mult_inv_sched.sv - scoreboard bench for mult_inv_sched with a behavioural MultInv core
`ifndef PRIME
`define PRIME 23
`endif
`ifndef BW_GF
`define BW_GF 5
`endif

module tb_mult_inv_sched;
  localparam int NREQ = 2;
  localparam int BW   = `BW_GF;
  localparam int P    = `PRIME;
  localparam int DRN  = 600;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BW-1:0]   req_a = '0;
  logic [NREQ-1:0]      gnt;
  logic                 done;
  logic [2:0]           done_id;
  logic [BW-1:0]        result;
  logic                 err, busy, mi_en;
  logic [BW-1:0]        mi_a;
  logic [BW-1:0]        mi_value = '0;
  logic [8:0]           mi_power = '0;
  logic                 mi_valid = 1'b0;

  typedef struct {
    int id;
    int a;
    int res;
    int err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   en_cnt = 0;
  int   run_len = 3;
  int   force_k = -1;
  int   last_k = 0;
  time  t_valid = 0;
  bit   twohot = 1'b0;

  mult_inv_sched #(.NREQ(NREQ), .DRAIN_CYC(DRN)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .gnt(gnt), .done(done),
    .done_id(done_id), .result(result), .err(err), .busy(busy), .mi_en(mi_en),
    .mi_a(mi_a), .mi_value(mi_value), .mi_power(mi_power), .mi_valid(mi_valid)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  function automatic int inv_mod(input int a);
    for (int x = 1; x < P; x++) if ((a * x) % P == 1) return x;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Almost-inverse reply: a^-1 * 2^k mod p, sometimes left unreduced by one p.
  task automatic emit(input int a);
    int v, k;
    k = (force_k >= 0) ? force_k : int'($urandom_range(0, 12));
    v = inv_mod(a);
    for (int i = 0; i < k; i++) v = (v * 2) % P;
    if ((v + P < (1 << BW)) && ($urandom_range(0, 1) == 1)) v += P;
    mi_value = BW'(v);
    mi_power = 9'(k);
    mi_valid = 1'b1;
    t_valid  = $time;
    last_k   = k;
  endtask

  // Non-resettable core model: keeps running across DUT resets.
  initial begin : core
    int  cd, ca;
    bit  cbusy;
    cd = 0; ca = 0; cbusy = 1'b0;
    forever begin
      @(negedge clk);
      if ($countones(gnt) > 1) twohot = 1'b1;
      mi_valid = 1'b0;
      if (cbusy) begin
        cd--;
        if (cd <= 0) begin
          cbusy = 1'b0;
          emit(ca);
        end
      end
      if (mi_en) begin
        en_cnt++;
        ca    = int'(mi_a);
        cbusy = 1'b1;
        cd    = run_len;
      end
    end
  end

  task automatic start(input int id, input int a, input int exp_res, input bit push);
    exp_t e;
    req_a[id*BW +: BW] = BW'(a);
    req[id] = 1'b1;
    e.id  = id;
    e.a   = a;
    e.err = ((a == 0) || (a >= P)) ? 1 : 0;
    e.res = e.err ? 0 : ((exp_res >= 0) ? exp_res : inv_mod(a));
    if (push) sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int id);
    exp_t e;
    int   n;
    bit   got;
    n = 0; got = 1'b0; id = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    chk({tag, "_seen"}, int'(got), 1);
    if (got) begin
      chk({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        id = int'(done_id);
        chk({tag, "_id"}, int'(done_id), e.id);
        chk({tag, "_result"}, int'(result), e.res);
        chk({tag, "_err"}, int'(err), e.err);
        chk({tag, "_gnt"}, int'(gnt), 1 << e.id);
        chk({tag, "_en_pulses"}, en_cnt, e.err ? 0 : 1);
        if (e.err) begin
          if (exp_lat > 0) chk({tag, "_lat"}, n, exp_lat);
        end else begin
          chk({tag, "_inv"}, (int'(result) * e.a) % P, 1);
          chk({tag, "_corr_cyc"}, int'(($time - t_valid) / 10), last_k + 2);
        end
      end
      en_cnt = 0;
    end
  endtask

  task automatic op(input string tag, input int id, input int a, input int exp_res, input int lat);
    int did;
    start(id, a, exp_res, 1'b1);
    wait_done(tag, lat, did);
    req[id] = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int n, did, issued;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mi_en", int'(mi_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    chk("drain_len", n, DRN);
    chk("drain_no_en", en_cnt, 0);
    en_cnt = 0;

    // T1 / T2
    op("t1_a3", 0, 3, 8, 0);
    op("t2_a5", 1, 5, 14, 0);
    force_k = 0;
    op("t2_a1_k0", 1, 1, 1, 0);
    force_k = 12;
    op("t2_a22", 1, 22, 22, 0);
    force_k = -1;

    // T3: simultaneous requests, then re-raise req[0] during op 1
    start(0, 6, -1, 1'b1);
    start(1, 10, -1, 1'b1);
    wait_done("t3_first", 0, did);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    start(0, 17, -1, 1'b1);
    wait_done("t3_second", 0, did);
    req[1] = 1'b0;
    wait_done("t3_third", 0, did);
    req[0] = 1'b0;
    @(negedge clk);

    // T4: error operands
    op("t4_a0", 0, 0, 0, 2);
    op("t4_a23", 1, 23, 0, 2);
    op("t4_a31", 0, 31, 0, 2);

    // Dropped request still completes
    start(0, 4, -1, 1'b1);
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    wait_done("drop_req", 0, did);
    @(negedge clk);

    // T5: reset during WAIT, request held through the drain
    run_len = 10;
    start(0, 7, -1, 1'b0);
    n = 0;
    while (en_cnt == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_launched", en_cnt, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_done", int'(done), 0);
    chk("t5_rst_mi_en", int'(mi_en), 0);
    @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    run_len = 3;
    start(0, 9, 18, 1'b1);
    n = 0;
    while (gnt == '0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("t5_drain_early_exit", int'(n > 0 && n < DRN), 1);
    wait_done("t5_new", 0, did);
    req[0] = 1'b0;
    @(negedge clk);

    // T6: 200 back-to-back ops on both requesters; rr points at 1 here
    start(1, int'($urandom_range(1, P - 1)), -1, 1'b1);
    start(0, int'($urandom_range(1, P - 1)), -1, 1'b1);
    issued = 2;
    for (int i = 0; i < 200; i++) begin
      run_len = int'($urandom_range(1, 5));
      wait_done("t6", 0, did);
      if (did < 0 || did >= NREQ) did = 0;
      if (issued < 200) begin
        start(did, int'($urandom_range(1, P - 1)), -1, 1'b1);
        issued++;
      end else begin
        req[did] = 1'b0;
      end
    end
    @(negedge clk);
    chk("gnt_never_2hot", int'(twohot), 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
